// File: rtl/restoring_div_4bit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : restoring_div_4bit_if
// Description : Request/result bundle for the 4-bit restoring divider.
//               The master issues start with operands and the slave returns
//               status and results.
// Revision    : 1.0 - initial release
// ============================================================================
interface restoring_div_4bit_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/restoring_div_4bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : restoring_div_4bit
// Description : Sequential 4-bit unsigned restoring divider. The quotient is
//               resolved MSB first, one bit per clock, over four CALC cycles.
//               A zero divisor short-cuts straight to DONE with a saturated
//               quotient, remainder equal to the dividend, and a flag set.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_div_4bit (
    input  wire logic             clk,
    input  wire logic             rst,
    restoring_div_4bit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [1:0] r_cnt;
    logic [3:0] r_rem;
    logic [3:0] r_dividend;
    logic [3:0] r_divisor;
    logic [3:0] r_quotient;
    logic [3:0] r_remainder;
    logic       r_dbz;

    logic       w_accept;
    logic       w_div_zero;
    logic [4:0] w_partial;
    logic [5:0] w_sum;
    logic [4:0] w_trial;
    logic       w_no_borrow;
    logic [3:0] w_rem_next;
    logic       w_unused_trial_msb;

    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_div_zero = (bus.divisor == 4'd0);

    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor. The carry out of the 6-bit sum is the
    // "no borrow" indication (partial >= divisor).
    assign w_partial   = {r_rem, r_dividend[r_cnt]};
    assign w_sum       = {1'b0, w_partial} + {1'b0, ~{1'b0, r_divisor}} + 6'd1;
    assign w_trial     = w_sum[4:0];
    assign w_no_borrow = w_sum[5];

    // Because R < divisor is kept invariant, a successful trial is always
    // below the divisor and fits in 4 bits; its top bit is always zero.
    assign w_rem_next         = w_no_borrow ? w_trial[3:0] : w_partial[3:0];
    assign w_unused_trial_msb = w_trial[4];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == 2'd0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 2'd0;
            r_rem       <= 4'd0;
            r_dividend  <= 4'd0;
            r_divisor   <= 4'd0;
            r_quotient  <= 4'd0;
            r_remainder <= 4'd0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
            r_rem      <= 4'd0;
            r_cnt      <= 2'd3;
            r_dbz      <= w_div_zero;
            if (w_div_zero) begin
                r_quotient  <= 4'hF;
                r_remainder <= bus.dividend;
            end
        end else if (r_state == CALC) begin
            r_quotient[r_cnt] <= w_no_borrow;
            r_rem             <= w_rem_next;
            r_cnt             <= r_cnt - 2'd1;
            if (r_cnt == 2'd0) begin
                r_remainder <= w_rem_next;
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/restoring_div_4bit.md
RESTORING_DIV_4BIT -- requirements
Module: restoring_div_4bit

Interface
REQ-001 Parameters: none; operand and result width SHALL be fixed at 4 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-005 dividend  input  4  unsigned dividend; captured when start is accepted.
REQ-006 divisor  input  4  unsigned divisor; captured when start is accepted.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse; results are valid in that cycle.
REQ-009 quotient  output  4  unsigned quotient, registered.
REQ-010 remainder  output  4  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  high when the last accepted divisor was 0, registered.

Function
REQ-012 States SHALL be IDLE, CALC and DONE, with 2-bit iteration counter cnt.
REQ-013 IDLE with start=1 at an edge SHALL accept: latch dividend and divisor, clear partial remainder R (4 bits), set cnt=3, clear div_by_zero.
REQ-014 After acceptance with divisor!=0, the next state SHALL be CALC.
REQ-015 After acceptance with divisor==0, the next state SHALL be DONE, with quotient=4'hF, remainder=dividend and div_by_zero=1.
REQ-016 Each CALC edge SHALL form trial = {R, dividend[cnt]} - {1'b0, divisor} as a 5-bit unsigned subtraction (a + ~b + 1).
REQ-017 No borrow (carry-out=1, trial >= 0) SHALL set quotient bit cnt to 1 and load R with trial[3:0].
REQ-018 A borrow SHALL set quotient bit cnt to 0 and load R with {R, dividend[cnt]}[3:0].
REQ-019 CALC SHALL run exactly 4 edges, cnt=3..0 (MSB first); the edge at cnt=0 SHALL load remainder=R and go to DONE.
REQ-020 The 5-bit trial SHALL never overflow, because R < divisor <= 15 is invariant.
REQ-021 DONE SHALL last exactly one cycle with done=1 and SHALL return to IDLE unconditionally.
REQ-022 Latency: done SHALL be high in the 5th cycle after the accepting edge for divisor!=0, and in the 1st cycle after it for divisor==0.
REQ-023 start SHALL be ignored in CALC and DONE; no queuing, no effect on results.
REQ-024 A start in the cycle after done (IDLE) SHALL be accepted, giving back-to-back throughput of one result per 6 cycles.
REQ-025 quotient, remainder and div_by_zero SHALL hold their last values in IDLE until the next completed operation.
REQ-026 Intermediate quotient bits MAY be visible during CALC; consumers SHALL qualify results with done only.
REQ-027 Input changes outside the accepting edge SHALL have no effect on an operation in progress.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, R=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-029 Reset asserted mid-CALC or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-030 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Bench SHALL cover: dividend=13, divisor=3 -> done 5 cycles after accept, quotient=4, remainder=1, div_by_zero=0.
REQ-032 Bench SHALL cover: 15/1 -> quotient=15, remainder=0; and 15/15 -> quotient=1, remainder=0.
REQ-033 Bench SHALL cover: 2/7 -> quotient=0, remainder=2; and 0/5 -> quotient=0, remainder=0.
REQ-034 Bench SHALL cover: 9/0 -> done 1 cycle after accept, quotient=4'hF, remainder=9, div_by_zero=1; then 8/2 -> quotient=4, remainder=0, div_by_zero=0.
REQ-035 Bench SHALL cover: 13/3 started, then start with 6/2 pulsed during CALC -> still quotient=4, remainder=1, and only one done pulse.
REQ-036 Bench SHALL cover: rst pulsed in the 2nd CALC cycle -> all outputs 0 immediately, no done; then 14/4 after release -> quotient=3, remainder=2.
REQ-037 Bench SHALL cover: exhaustive sweep of all 256 operand pairs checked against a behavioural a/b and a%b model, with the divisor-0 rule applied.
